trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
- Sequencer for trap entry and `mret` return in the single-cycle NPC core.
- Arbitrates pending exception and interrupt sources at an instruction boundary.
- Drives the CSR file's single write port one register per cycle (mepc, mcause, mstatus), then redirects the PC to mtvec (trap) or mepc (mret).
- Sits between the decode/execute stage and the CSR file; the CSR file's `intr` input is tied to 0, so all CSR updates go through this block.

Parameters:
- DATA_WIDTH, 32, width of PC, CSR address and CSR data.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, rst asynchronous and active-low
- inst_valid  in  1  instruction at the boundary is valid; requests are sampled only when high
- inst_pc  in  DATA_WIDTH  PC of that instruction
- ecall  in  1  environment call
- ebreak  in  1  breakpoint
- illegal  in  1  illegal instruction
- mret  in  1  return from trap
- irq_ext  in  1  external interrupt, level
- irq_timer  in  1  timer interrupt, level
- busy  out  1  pipeline must stall while high
- csr_wen  out  1  CSR write enable
- csr_addr  out  DATA_WIDTH  CSR address
- csr_wdata  out  DATA_WIDTH  CSR write data
- csr_rdata  in  DATA_WIDTH  combinational read data for csr_addr
- redirect_valid  out  1  one-cycle pulse
- redirect_pc  out  DATA_WIDTH  target PC, valid with redirect_valid

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; busy, csr_wen, redirect_valid = 0; csr_addr, csr_wdata, redirect_pc = 0; latched cause/epc = 0. Reset asserted mid-sequence aborts it immediately. Partial CSR writes already done stay in place.
- MIE is sampled from mstatus[3] via csr_rdata. In IDLE, csr_addr = 0x300 and csr_wen = 0.
- Priority in IDLE with inst_valid=1 (highest first):
  - irq_ext && MIE → cause 0x8000000B
  - irq_timer && MIE → cause 0x80000007
  - illegal → 2
  - ebreak → 3
  - ecall → 11
  - mret
  - Lower requests in the same cycle are dropped; the pipeline re-presents them.
- On accept: latch epc = inst_pc and the cause; busy=1 from the next cycle until the redirect cycle inclusive. Request inputs are ignored while busy.
- Trap state sequence:
  - T_EPC: wen=1, addr 0x341, wdata epc.
  - T_CAUSE: wen=1, addr 0x342, wdata cause.
  - T_STATUS: addr 0x300, wen=1, wdata = rdata with bit7 = rdata[3], bit3 = 0, bits[12:11] = 2'b11.
  - T_VEC: addr 0x305, wen=0; redirect_pc = {rdata[DW-1:2], 2'b00}; redirect_valid=1.
  - Then IDLE.
  - Trap latency: accept edge + 4 cycles, redirect in the 4th.
- mret state sequence:
  - M_STATUS: addr 0x300, wen=1, wdata = rdata with bit3 = rdata[7], bit7 = 1, bits[12:11] = 2'b11.
  - M_EPC: addr 0x341, wen=0; redirect_pc = rdata; redirect_valid=1.
  - Then IDLE.
- Outputs are registered per state, except csr_wdata and redirect_pc, which are combinational from csr_rdata in the STATUS and VEC/EPC states.
- The write address is never 0, so the CSR file's `addr!=0` guard never blocks a write.
- An interrupt raised and dropped while busy is not remembered (level-sensitive).

Optional Feature:
- Macro: TRAP_CTRL_VECTORED_EN.
- Defined: in T_VEC, if mtvec[1:0]==2'b01 and the cause is an interrupt, redirect_pc = base + 4*cause[DW-2:0]; exceptions and mode 00 still use base.
- Undefined: always direct mode (base), mode bits ignored.

Decomposition:
- Shared package `trap_pkg` holds:
  - CSR address constants (0x300, 0x305, 0x341, 0x342).
  - Cause codes.
  - mstatus bit indices (MIE=3, MPIE=7, MPP=12:11).
  - State enum.
- One natural sub-module: `trap_prio_enc`, a combinational priority encoder producing {take, is_mret, cause}.

Test Plan:
- ecall at pc 0x80000010, mtvec=0x80001000, mstatus=0x8 → writes mepc=0x80000010, mcause=11, mstatus=0x1880; redirect_pc 0x80001000 in cycle 4; busy high cycles 1–4.
- mret after the above, mepc=0x80000010, mstatus=0x1880 → mstatus written 0x1888; redirect_pc 0x80000010 in cycle 2.
- irq_timer + ecall same cycle, MIE=1 → mcause 0x80000007; with MIE=0 → mcause 11.
- irq_ext + irq_timer, MIE=1 → mcause 0x8000000B; mtvec=0x80001001 with TRAP_CTRL_VECTORED_EN → redirect 0x8000102C, without the macro → 0x80001000.
- rst pulsed low during T_CAUSE → all outputs 0 immediately; mepc keeps the new value; next ecall completes normally.
- illegal with inst_valid=0 → no accept, busy stays 0, no CSR write.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared constants and state encoding for the trap entry / mret sequencer.
package trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // Cause codes; bit DW-1 (interrupt flag) is added by the encoder.
  localparam logic [4:0] CODE_M_EXT_IRQ   = 5'd11;
  localparam logic [4:0] CODE_M_TIMER_IRQ = 5'd7;
  localparam logic [4:0] CODE_ILLEGAL     = 5'd2;
  localparam logic [4:0] CODE_BREAKPOINT  = 5'd3;
  localparam logic [4:0] CODE_ECALL_M     = 5'd11;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T_EPC,
    S_T_CAUSE,
    S_T_STATUS,
    S_T_VEC,
    S_M_STATUS,
    S_M_EPC
  } state_e;

endpackage

// File: rtl/trap_prio_enc.sv
// Combinational priority encoder for trap / mret requests at an instruction boundary.
module trap_prio_enc
  import trap_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  valid,
  input  logic                  mie,
  input  logic                  irq_ext,
  input  logic                  irq_timer,
  input  logic                  illegal,
  input  logic                  ebreak,
  input  logic                  ecall,
  input  logic                  mret,
  output logic                  take_c,
  output logic                  is_mret_c,
  output logic [DATA_WIDTH-1:0] cause_c
);

  localparam int unsigned CW = DATA_WIDTH - 1;

  // Interrupts (gated by MIE) beat exceptions, which beat mret.
  always_comb begin
    take_c    = 1'b0;
    is_mret_c = 1'b0;
    cause_c   = '0;
    if (valid) begin
      if (irq_ext && mie) begin
        take_c  = 1'b1;
        cause_c = {1'b1, CW'(CODE_M_EXT_IRQ)};
      end else if (irq_timer && mie) begin
        take_c  = 1'b1;
        cause_c = {1'b1, CW'(CODE_M_TIMER_IRQ)};
      end else if (illegal) begin
        take_c  = 1'b1;
        cause_c = {1'b0, CW'(CODE_ILLEGAL)};
      end else if (ebreak) begin
        take_c  = 1'b1;
        cause_c = {1'b0, CW'(CODE_BREAKPOINT)};
      end else if (ecall) begin
        take_c  = 1'b1;
        cause_c = {1'b0, CW'(CODE_ECALL_M)};
      end else if (mret) begin
        take_c    = 1'b1;
        is_mret_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap entry / mret sequencer driving the CSR write port and PC redirect.
// Optional vectored mtvec mode enabled by defining TRAP_CTRL_VECTORED_EN.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_valid,
  input  logic [DATA_WIDTH-1:0] inst_pc,
  input  logic                  ecall,
  input  logic                  ebreak,
  input  logic                  illegal,
  input  logic                  mret,
  input  logic                  irq_ext,
  input  logic                  irq_timer,
  output logic                  busy,
  output logic                  csr_wen,
  output logic [DATA_WIDTH-1:0] csr_addr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc
);

  localparam int unsigned DW = DATA_WIDTH;

  state_e        state_q, state_d;
  logic          busy_d, wen_d, rv_d;
  logic [DW-1:0] addr_d;
  logic [DW-1:0] epc_q, cause_q;
  logic          idle_c, mie_c, take_c, is_mret_c;
  logic [DW-1:0] cause_c;
  logic [DW-1:0] status_trap_c, status_mret_c, base_c, vec_pc_c;

  assign idle_c = (state_q == S_IDLE);
  // MIE is only trusted while the read port really points at mstatus.
  assign mie_c  = idle_c && (csr_addr == DW'(CSR_MSTATUS)) && csr_rdata[MSTATUS_MIE];

  trap_prio_enc #(.DATA_WIDTH(DW)) u_prio (
    .valid     (inst_valid && idle_c),
    .mie       (mie_c),
    .irq_ext   (irq_ext),
    .irq_timer (irq_timer),
    .illegal   (illegal),
    .ebreak    (ebreak),
    .ecall     (ecall),
    .mret      (mret),
    .take_c    (take_c),
    .is_mret_c (is_mret_c),
    .cause_c   (cause_c)
  );

  // Next state and the registered per-state outputs it implies.
  always_comb begin
    state_d = state_q;
    busy_d  = 1'b0;
    wen_d   = 1'b0;
    rv_d    = 1'b0;
    addr_d  = DW'(CSR_MSTATUS);
    case (state_q)
      S_IDLE:     if (take_c) state_d = is_mret_c ? S_M_STATUS : S_T_EPC;
      S_T_EPC:    state_d = S_T_CAUSE;
      S_T_CAUSE:  state_d = S_T_STATUS;
      S_T_STATUS: state_d = S_T_VEC;
      S_T_VEC:    state_d = S_IDLE;
      S_M_STATUS: state_d = S_M_EPC;
      S_M_EPC:    state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    case (state_d)
      S_T_EPC:    begin busy_d = 1'b1; wen_d = 1'b1; addr_d = DW'(CSR_MEPC);    end
      S_T_CAUSE:  begin busy_d = 1'b1; wen_d = 1'b1; addr_d = DW'(CSR_MCAUSE);  end
      S_T_STATUS: begin busy_d = 1'b1; wen_d = 1'b1; addr_d = DW'(CSR_MSTATUS); end
      S_T_VEC:    begin busy_d = 1'b1; rv_d  = 1'b1; addr_d = DW'(CSR_MTVEC);   end
      S_M_STATUS: begin busy_d = 1'b1; wen_d = 1'b1; addr_d = DW'(CSR_MSTATUS); end
      S_M_EPC:    begin busy_d = 1'b1; rv_d  = 1'b1; addr_d = DW'(CSR_MEPC);    end
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      busy           <= 1'b0;
      csr_wen        <= 1'b0;
      csr_addr       <= '0;
      redirect_valid <= 1'b0;
      epc_q          <= '0;
      cause_q        <= '0;
    end else begin
      state_q        <= state_d;
      busy           <= busy_d;
      csr_wen        <= wen_d;
      csr_addr       <= addr_d;
      redirect_valid <= rv_d;
      if (idle_c && take_c) begin
        epc_q   <= inst_pc;
        cause_q <= cause_c;
      end
    end
  end

  // mstatus images for trap entry and return, built from the live read data.
  always_comb begin
    status_trap_c                                = csr_rdata;
    status_trap_c[MSTATUS_MPIE]                  = csr_rdata[MSTATUS_MIE];
    status_trap_c[MSTATUS_MIE]                   = 1'b0;
    status_trap_c[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    status_mret_c                                = csr_rdata;
    status_mret_c[MSTATUS_MIE]                   = csr_rdata[MSTATUS_MPIE];
    status_mret_c[MSTATUS_MPIE]                  = 1'b1;
    status_mret_c[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  assign base_c = {csr_rdata[DW-1:2], 2'b00};

`ifdef TRAP_CTRL_VECTORED_EN
  assign vec_pc_c = ((csr_rdata[1:0] == 2'b01) && cause_q[DW-1])
                    ? base_c + DW'({cause_q[DW-2:0], 2'b00})
                    : base_c;
`else
  assign vec_pc_c = base_c;
`endif

  always_comb begin
    csr_wdata   = '0;
    redirect_pc = '0;
    case (state_q)
      S_T_EPC:    csr_wdata   = epc_q;
      S_T_CAUSE:  csr_wdata   = cause_q;
      S_T_STATUS: csr_wdata   = status_trap_c;
      S_M_STATUS: csr_wdata   = status_mret_c;
      S_T_VEC:    redirect_pc = vec_pc_c;
      S_M_EPC:    redirect_pc = csr_rdata;
      default:    ;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl with a small CSR file model on its write port.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid, ecall, ebreak, illegal, mret, irq_ext, irq_timer;
  logic [31:0] inst_pc;
  logic        busy, csr_wen, redirect_valid;
  logic [31:0] csr_addr, csr_wdata, csr_rdata, redirect_pc;

  logic [31:0] mstatus, mtvec, mepc, mcause;
  logic        set_en;
  logic [31:0] set_addr, set_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  trap_ctrl #(.DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .inst_valid     (inst_valid),
    .inst_pc        (inst_pc),
    .ecall          (ecall),
    .ebreak         (ebreak),
    .illegal        (illegal),
    .mret           (mret),
    .irq_ext        (irq_ext),
    .irq_timer      (irq_timer),
    .busy           (busy),
    .csr_wen        (csr_wen),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  // CSR file model: combinational read, write on clock edge; not reset by rst.
  always_comb begin
    case (csr_addr)
      32'h300: csr_rdata = mstatus;
      32'h305: csr_rdata = mtvec;
      32'h341: csr_rdata = mepc;
      32'h342: csr_rdata = mcause;
      default: csr_rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    logic        we;
    logic [31:0] wa, wd;
    we = csr_wen | set_en;
    wa = csr_wen ? csr_addr : set_addr;
    wd = csr_wen ? csr_wdata : set_data;
    if (we) begin
      case (wa)
        32'h300: mstatus <= wd;
        32'h305: mtvec   <= wd;
        32'h341: mepc    <= wd;
        32'h342: mcause  <= wd;
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preset(input logic [31:0] a, input logic [31:0] d);
    set_en   = 1'b1;
    set_addr = a;
    set_data = d;
    tick();
    set_en   = 1'b0;
  endtask

  task automatic clear_req();
    inst_valid = 1'b0; ecall = 1'b0; ebreak = 1'b0; illegal = 1'b0;
    mret = 1'b0; irq_ext = 1'b0; irq_timer = 1'b0;
  endtask

  // Requests are already driven; walk the four trap cycles.
  task automatic run_trap(input logic [31:0] epc, input logic [31:0] cause,
                          input logic [31:0] status, input logic [31:0] rpc);
    tick();
    clear_req();
    check("t1_busy", busy, 1);
    check("t1_wen", csr_wen, 1);
    check("t1_addr", csr_addr, 32'h341);
    check("t1_wdata", csr_wdata, epc);
    tick();
    check("t2_addr", csr_addr, 32'h342);
    check("t2_wdata", csr_wdata, cause);
    tick();
    check("t3_addr", csr_addr, 32'h300);
    check("t3_wen", csr_wen, 1);
    check("t3_wdata", csr_wdata, status);
    tick();
    check("t4_busy", busy, 1);
    check("t4_wen", csr_wen, 0);
    check("t4_rv", redirect_valid, 1);
    check("t4_rpc", redirect_pc, rpc);
    tick();
    check("t5_busy", busy, 0);
    check("t5_rv", redirect_valid, 0);
    check("t5_addr", csr_addr, 32'h300);
    check("mepc", mepc, epc);
    check("mcause", mcause, cause);
    check("mstatus", mstatus, status);
  endtask

  initial begin
    rst = 1'b0;
    set_en = 1'b0; set_addr = 0; set_data = 0;
    inst_pc = 0;
    clear_req();
    mstatus = 0; mtvec = 0; mepc = 0; mcause = 0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_wen", csr_wen, 0);
    check("rst_addr", csr_addr, 0);
    check("rst_wdata", csr_wdata, 0);
    check("rst_rv", redirect_valid, 0);
    check("rst_rpc", redirect_pc, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("idle_addr", csr_addr, 32'h300);
    preset(32'h300, 32'h8);
    preset(32'h305, 32'h8000_1000);

    // ecall
    inst_valid = 1'b1; inst_pc = 32'h8000_0010; ecall = 1'b1;
    run_trap(32'h8000_0010, 32'd11, 32'h1880, 32'h8000_1000);

    // mret
    inst_valid = 1'b1; mret = 1'b1;
    tick();
    clear_req();
    check("m1_busy", busy, 1);
    check("m1_wen", csr_wen, 1);
    check("m1_addr", csr_addr, 32'h300);
    check("m1_wdata", csr_wdata, 32'h1888);
    tick();
    check("m2_wen", csr_wen, 0);
    check("m2_rv", redirect_valid, 1);
    check("m2_rpc", redirect_pc, 32'h8000_0010);
    tick();
    check("m3_busy", busy, 0);
    check("m3_rv", redirect_valid, 0);
    check("m_mstatus", mstatus, 32'h1888);

    // timer + ecall, MIE=1 then MIE=0
    inst_valid = 1'b1; inst_pc = 32'h8000_0020; irq_timer = 1'b1; ecall = 1'b1;
    run_trap(32'h8000_0020, 32'h8000_0007, 32'h1880, 32'h8000_1000);
    inst_valid = 1'b1; inst_pc = 32'h8000_0024; irq_timer = 1'b1; ecall = 1'b1;
    run_trap(32'h8000_0024, 32'd11, 32'h1800, 32'h8000_1000);

    // ext + timer, vectored mtvec
    preset(32'h300, 32'h8);
    preset(32'h305, 32'h8000_1001);
    inst_valid = 1'b1; inst_pc = 32'h8000_0030; irq_ext = 1'b1; irq_timer = 1'b1;
`ifdef TRAP_CTRL_VECTORED_EN
    run_trap(32'h8000_0030, 32'h8000_000B, 32'h1880, 32'h8000_102C);
`else
    run_trap(32'h8000_0030, 32'h8000_000B, 32'h1880, 32'h8000_1000);
`endif

    // illegal beats ebreak/ecall
    preset(32'h305, 32'h8000_1000);
    inst_valid = 1'b1; inst_pc = 32'h8000_0034; illegal = 1'b1; ebreak = 1'b1; ecall = 1'b1;
    run_trap(32'h8000_0034, 32'd2, 32'h1800, 32'h8000_1000);
    inst_valid = 1'b1; inst_pc = 32'h8000_0038; ebreak = 1'b1; ecall = 1'b1;
    run_trap(32'h8000_0038, 32'd3, 32'h1800, 32'h8000_1000);

    // reset during T_CAUSE
    preset(32'h300, 32'h8);
    inst_valid = 1'b1; inst_pc = 32'h8000_0040; ecall = 1'b1;
    tick();
    clear_req();
    tick();
    check("r_in_cause", csr_addr, 32'h342);
    rst = 1'b0;
    #1;
    check("r_busy", busy, 0);
    check("r_wen", csr_wen, 0);
    check("r_addr", csr_addr, 0);
    check("r_wdata", csr_wdata, 0);
    check("r_rv", redirect_valid, 0);
    check("r_rpc", redirect_pc, 0);
    tick();
    check("r_mepc", mepc, 32'h8000_0040);
    check("r_mcause", mcause, 32'd3);
    check("r_mstatus", mstatus, 32'h8);
    @(negedge clk);
    rst = 1'b1;
    tick();
    inst_valid = 1'b1; inst_pc = 32'h8000_0050; ecall = 1'b1;
    run_trap(32'h8000_0050, 32'd11, 32'h1880, 32'h8000_1000);

    // illegal without inst_valid
    illegal = 1'b1; inst_pc = 32'h8000_0060;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("nv_busy", busy, 0);
      check("nv_wen", csr_wen, 0);
    end
    clear_req();
    check("nv_mcause", mcause, 32'd11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
